mcsr_spmv_array: RTL and testbench

Parametrised multi-lane sparse matrix-vector multiply engine for Modified-CSR storage. Each of `LANES` row lanes streams its row's stored nonzeros (value and column index) from a per-lane row memory, fetches the matching vector element, and accumulates a signed dot product. A single start/done handshake controls the whole array. It replaces the five fixed, free-running HLS MAC instances with one controllable, resettable block that feeds the same block-RAM style memories.

---
 rtl/mcsr_spmv_array_pkg.sv | 26 ++
 rtl/mcsr_spmv_array_if.sv | 42 ++++
 rtl/mcsr_spmv_array_lane.sv | 144 ++++++++++++++
 rtl/mcsr_spmv_array.sv | 73 +++++++
 tb/tb_mcsr_spmv_array.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcsr_spmv_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcsr_pkg
//  Description : Shared types and constants for the Modified-CSR SpMV array.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcsr_pkg;

    // Lane controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lane_state_e;

    // Default geometry
    localparam int MCSR_LANES  = 5;
    localparam int MCSR_DATA_W = 32;
    localparam int MCSR_ADDR_W = 3;
    localparam int MCSR_ACC_W  = 64;

    // Cycles from the last issued row address to the final accumulate + 1
    localparam int MCSR_LAT    = 3;

endpackage : mcsr_pkg
`default_nettype wire

// File: rtl/mcsr_spmv_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcsr_spmv_array_if
//  Description : Control handshake and flattened per-lane memory buses of the
//                SpMV array. The slave side is the engine, the master side is
//                the controller plus the row/vector memories.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcsr_spmv_array_if
    import mcsr_pkg::*;
#(
    parameter int LANES  = MCSR_LANES,
    parameter int DATA_W = MCSR_DATA_W,
    parameter int ADDR_W = MCSR_ADDR_W,
    parameter int ACC_W  = MCSR_ACC_W
);
    logic                         start;
    logic [LANES*(ADDR_W+1)-1:0]  row_len;
    logic                         busy;
    logic                         done;
    logic [LANES-1:0]             mat_ce;
    logic [LANES*ADDR_W-1:0]      mat_addr;
    logic [LANES*DATA_W-1:0]      mat_val;
    logic [LANES*ADDR_W-1:0]      mat_col;
    logic [LANES-1:0]             x_ce;
    logic [LANES*ADDR_W-1:0]      x_addr;
    logic [LANES*DATA_W-1:0]      x_data;
    logic [LANES*ACC_W-1:0]       y;
    logic [LANES-1:0]             y_vld;

    modport slave (
        input  start, row_len, mat_val, mat_col, x_data,
        output busy, done, mat_ce, mat_addr, x_ce, x_addr, y, y_vld
    );

    modport master (
        output start, row_len, mat_val, mat_col, x_data,
        input  busy, done, mat_ce, mat_addr, x_ce, x_addr, y, y_vld
    );

endinterface : mcsr_spmv_array_if
`default_nettype wire

// File: rtl/mcsr_spmv_array_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mcsr_spmv_lane
//  Description : One row lane: index counter, row-memory read, vector gather,
//                signed multiply-accumulate and result register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcsr_spmv_lane
    import mcsr_pkg::*;
#(
    parameter int DATA_W = MCSR_DATA_W,
    parameter int ADDR_W = MCSR_ADDR_W,
    parameter int ACC_W  = MCSR_ACC_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start_i,     // accepted start (already gated by busy)
    input  wire logic [ADDR_W:0]     row_len_i,
    input  wire logic [DATA_W-1:0]   mat_val_i,
    input  wire logic [ADDR_W-1:0]   mat_col_i,
    input  wire logic [DATA_W-1:0]   x_data_i,
    output logic                     mat_ce_o,
    output logic [ADDR_W-1:0]        mat_addr_o,
    output logic                     x_ce_o,
    output logic [ADDR_W-1:0]        x_addr_o,
    output logic [ACC_W-1:0]         y_o,
    output logic                     y_vld_o,
    output logic                     fin_o        // lane is, or becomes at this edge, finished
);

    localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic            DRAIN_LAST = 1'(MCSR_LAT - 2);

    lane_state_e                state_q;
    logic [ADDR_W:0]            len_q;
    logic                       mat_ce_q;
    logic [ADDR_W-1:0]          mat_addr_q;
    logic                       drain_q;
    logic                       y_vld_q;
    logic [ACC_W-1:0]           y_q;

    logic                       s1_vld_q;
    logic                       s2_vld_q;
    logic [DATA_W-1:0]          val_q;
    logic [ACC_W-1:0]           acc_q;

    logic [ADDR_W:0]            w_len;
    logic [ADDR_W:0]            w_next_idx;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]           w_prod_ext;
    logic [ACC_W-1:0]           acc_d;

    // Lengths beyond the row depth are clamped to a full row
    assign w_len      = (row_len_i > DEPTH) ? DEPTH : row_len_i;
    assign w_next_idx = {1'b0, mat_addr_q} + ONE;

    // Full-precision signed product, sign-extended or truncated to the accumulator
    assign w_prod     = $signed(val_q) * $signed(x_data_i);
    assign w_prod_ext = ACC_W'(w_prod);
    assign acc_d      = s2_vld_q ? (acc_q + w_prod_ext) : acc_q;

    // Lane FSM: issues row addresses in RUN, waits out the pipeline in DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            mat_ce_q   <= 1'b0;
            mat_addr_q <= '0;
            drain_q    <= 1'b0;
            y_vld_q    <= 1'b0;
            y_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= w_len;
                        y_vld_q <= 1'b0;
                        drain_q <= 1'b0;
                        if (w_len == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q    <= ST_RUN;
                            mat_ce_q   <= 1'b1;
                            mat_addr_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_next_idx == len_q) begin
                        state_q    <= ST_DRAIN;
                        mat_ce_q   <= 1'b0;
                        mat_addr_q <= '0;
                    end else begin
                        mat_addr_q <= w_next_idx[ADDR_W-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        drain_q <= 1'b0;
                        y_vld_q <= 1'b1;
                        y_q     <= acc_d;   // includes the accumulate of this very edge
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1/2 pipeline and accumulator; cleared by reset so nothing partial survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            val_q    <= '0;
            acc_q    <= '0;
        end else begin
            s1_vld_q <= mat_ce_q;
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                val_q <= mat_val_i;
            end
            if ((state_q == ST_IDLE) && start_i) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign mat_ce_o   = mat_ce_q;
    assign mat_addr_o = mat_addr_q;
    assign x_ce_o     = s1_vld_q;
    assign x_addr_o   = s1_vld_q ? mat_col_i : '0;
    assign y_o        = y_q;
    assign y_vld_o    = y_vld_q;
    assign fin_o      = ((state_q == ST_IDLE) && y_vld_q) ||
                        ((state_q == ST_DRAIN) && (drain_q == DRAIN_LAST));

endmodule : mcsr_spmv_lane
`default_nettype wire

// File: rtl/mcsr_spmv_array.sv
`default_nettype none
// ============================================================================
//  Module      : mcsr_spmv_array
//  Description : Multi-lane Modified-CSR sparse matrix-vector multiply array.
//                Holds start acceptance, busy/done and per-lane bus slicing.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcsr_spmv_array
    import mcsr_pkg::*;
#(
    parameter int LANES  = MCSR_LANES,
    parameter int DATA_W = MCSR_DATA_W,
    parameter int ADDR_W = MCSR_ADDR_W,
    parameter int ACC_W  = MCSR_ACC_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mcsr_spmv_array_if.slave   bus
);

    logic              busy_q;
    logic              done_q;
    logic              w_start_acc;
    logic [LANES-1:0]  w_fin;

    assign w_start_acc = bus.start & ~busy_q;

    // busy drops and done pulses in the first cycle every lane is idle with a result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_start_acc) begin
                busy_q <= 1'b1;
            end else if (busy_q && (&w_fin)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            mcsr_spmv_lane #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .start_i    (w_start_acc),
                .row_len_i  (bus.row_len[i*(ADDR_W+1) +: (ADDR_W+1)]),
                .mat_val_i  (bus.mat_val[i*DATA_W +: DATA_W]),
                .mat_col_i  (bus.mat_col[i*ADDR_W +: ADDR_W]),
                .x_data_i   (bus.x_data[i*DATA_W +: DATA_W]),
                .mat_ce_o   (bus.mat_ce[i]),
                .mat_addr_o (bus.mat_addr[i*ADDR_W +: ADDR_W]),
                .x_ce_o     (bus.x_ce[i]),
                .x_addr_o   (bus.x_addr[i*ADDR_W +: ADDR_W]),
                .y_o        (bus.y[i*ACC_W +: ACC_W]),
                .y_vld_o    (bus.y_vld[i]),
                .fin_o      (w_fin[i])
            );
        end
    endgenerate

endmodule : mcsr_spmv_array
`default_nettype wire

// File: tb/tb_mcsr_spmv_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcsr_spmv_array
//  Description : Self-checking bench for mcsr_spmv_array with row/vector
//                memory models and a dot-product reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcsr_spmv_array;

    localparam int LANES  = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int ACC_W  = 64;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    // Memory contents and reference results
    logic [DATA_W-1:0] vmem [LANES][DEPTH];
    logic [ADDR_W-1:0] cmem [LANES][DEPTH];
    logic [DATA_W-1:0] xmem [DEPTH];
    int unsigned       lens [LANES];
    logic [ACC_W-1:0]  yref [LANES];

    mcsr_spmv_array_if #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)
    ) ifc ();

    mcsr_spmv_array #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ifc.mat_ce[i]) begin
                ifc.mat_val[i*DATA_W +: DATA_W] <= vmem[i][ifc.mat_addr[i*ADDR_W +: ADDR_W]];
                ifc.mat_col[i*ADDR_W +: ADDR_W] <= cmem[i][ifc.mat_addr[i*ADDR_W +: ADDR_W]];
            end
            if (ifc.x_ce[i]) begin
                ifc.x_data[i*DATA_W +: DATA_W] <= xmem[ifc.x_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Address protocol monitor
    logic             prev_ce   [LANES];
    logic [ADDR_W-1:0] prev_addr [LANES];
    always @(negedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst_n) begin
                prev_ce[i]   = 1'b0;
                prev_addr[i] = '0;
            end else begin
                if (ifc.mat_ce[i] && prev_ce[i]) begin
                    total++;
                    if (ifc.mat_addr[i*ADDR_W +: ADDR_W] !== prev_addr[i] + 3'd1) begin
                        bad++;
                        $display("FAIL mat_addr_step lane%0d t=%0t: got %0d want %0d", i, $time,
                                 ifc.mat_addr[i*ADDR_W +: ADDR_W], prev_addr[i] + 3'd1);
                    end
                end
                if (!ifc.mat_ce[i]) begin
                    total++;
                    if (ifc.mat_addr[i*ADDR_W +: ADDR_W] !== '0) begin
                        bad++;
                        $display("FAIL mat_addr_idle lane%0d t=%0t: got %0d want 0", i, $time,
                                 ifc.mat_addr[i*ADDR_W +: ADDR_W]);
                    end
                end
                if (ifc.x_ce[i]) begin
                    total++;
                    if (!prev_ce[i] || ifc.x_addr[i*ADDR_W +: ADDR_W] !== cmem[i][prev_addr[i]]) begin
                        bad++;
                        $display("FAIL x_addr_follow lane%0d t=%0t: got %0d want %0d (prev_ce=%0d)", i, $time,
                                 ifc.x_addr[i*ADDR_W +: ADDR_W], cmem[i][prev_addr[i]], prev_ce[i]);
                    end
                end else begin
                    total++;
                    if (ifc.x_addr[i*ADDR_W +: ADDR_W] !== '0) begin
                        bad++;
                        $display("FAIL x_addr_idle lane%0d t=%0t: got %0d want 0", i, $time,
                                 ifc.x_addr[i*ADDR_W +: ADDR_W]);
                    end
                end
                prev_ce[i]   = ifc.mat_ce[i];
                prev_addr[i] = ifc.mat_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    function automatic int eff_len(input int unsigned l);
        return (l > DEPTH) ? DEPTH : int'(l);
    endfunction

    // Reference: y = sum over stored nonzeros of val * x[col], modulo 2^64
    function automatic void compute_ref();
        longint acc;
        for (int i = 0; i < LANES; i++) begin
            acc = 0;
            for (int k = 0; k < eff_len(lens[i]); k++) begin
                acc += longint'($signed(vmem[i][k])) * longint'($signed(xmem[cmem[i][k]]));
            end
            yref[i] = acc;
        end
    endfunction

    task automatic fill_random();
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                vmem[i][k] = $urandom;
                cmem[i][k] = 3'($urandom_range(0, DEPTH - 1));
            end
        end
        for (int k = 0; k < DEPTH; k++) xmem[k] = $urandom;
    endtask

    task automatic apply_lens();
        for (int i = 0; i < LANES; i++) ifc.row_len[i*(ADDR_W+1) +: (ADDR_W+1)] = 4'(lens[i]);
    endtask

    // Caller is one time unit after a rising edge; that cycle is cycle 0.
    task automatic run_and_check(input bit launch, input bit hold);
        int mx;
        int l;
        mx = 0;
        for (int i = 0; i < LANES; i++) if (eff_len(lens[i]) > mx) mx = eff_len(lens[i]);
        if (launch) ifc.start = 1'b1;
        for (int c = 1; c <= mx + 3; c++) begin
            @(posedge clk);
            #1;
            if (!hold) ifc.start = 1'b0;
            total++;
            if (ifc.busy !== (c < mx + 3)) begin
                bad++;
                $display("FAIL busy cyc%0d: got %0b want %0b", c, ifc.busy, (c < mx + 3));
            end
            total++;
            if (ifc.done !== (c == mx + 3)) begin
                bad++;
                $display("FAIL done cyc%0d: got %0b want %0b", c, ifc.done, (c == mx + 3));
            end
            for (int i = 0; i < LANES; i++) begin
                l = eff_len(lens[i]);
                total++;
                if (ifc.mat_ce[i] !== (c >= 1 && c <= l)) begin
                    bad++;
                    $display("FAIL mat_ce lane%0d cyc%0d: got %0b want %0b", i, c, ifc.mat_ce[i], (c >= 1 && c <= l));
                end
                total++;
                if (ifc.x_ce[i] !== (c >= 2 && c <= l + 1)) begin
                    bad++;
                    $display("FAIL x_ce lane%0d cyc%0d: got %0b want %0b", i, c, ifc.x_ce[i], (c >= 2 && c <= l + 1));
                end
                total++;
                if (ifc.y_vld[i] !== (c >= l + 3)) begin
                    bad++;
                    $display("FAIL y_vld lane%0d cyc%0d: got %0b want %0b", i, c, ifc.y_vld[i], (c >= l + 3));
                end
                if (c >= l + 3) begin
                    total++;
                    if (ifc.y[i*ACC_W +: ACC_W] !== yref[i]) begin
                        bad++;
                        $display("FAIL y lane%0d cyc%0d: got %0h want %0h", i, c, ifc.y[i*ACC_W +: ACC_W], yref[i]);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({ifc.busy, ifc.done, ifc.mat_ce, ifc.x_ce, ifc.y_vld} !== '0) begin
            bad++;
            $display("FAIL %s_ctrl: got busy=%0b done=%0b mat_ce=%0h x_ce=%0h y_vld=%0h want all 0",
                     tag, ifc.busy, ifc.done, ifc.mat_ce, ifc.x_ce, ifc.y_vld);
        end
        total++;
        if ({ifc.mat_addr, ifc.x_addr} !== '0) begin
            bad++;
            $display("FAIL %s_addr: got mat_addr=%0h x_addr=%0h want 0", tag, ifc.mat_addr, ifc.x_addr);
        end
        total++;
        if (ifc.y !== '0) begin
            bad++;
            $display("FAIL %s_y: got %0h want 0", tag, ifc.y);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        ifc.start   = 1'b0;
        ifc.row_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_lane();
        fill_random();
        lens = '{3, 0, 0, 0, 0};
        vmem[0][0] = 32'd2;  cmem[0][0] = 3'd0;
        vmem[0][1] = -32'sd3; cmem[0][1] = 3'd2;
        vmem[0][2] = 32'd4;  cmem[0][2] = 3'd4;
        xmem[0] = 32'd5;
        xmem[2] = 32'd1;
        xmem[4] = -32'sd2;
        compute_ref();
        apply_lens();
        run_and_check(1'b1, 1'b0);
    endtask

    task automatic test_mixed_lengths();
        fill_random();
        lens = '{0, 1, 4, 8, 2};
        compute_ref();
        apply_lens();
        run_and_check(1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                vmem[i][k] = 32'h8000_0000;
                cmem[i][k] = 3'($urandom_range(0, DEPTH - 1));
            end
        end
        for (int k = 0; k < DEPTH; k++) xmem[k] = 32'h8000_0000;
        lens = '{8, 8, 8, 8, 8};
        compute_ref();
        apply_lens();
        run_and_check(1'b1, 1'b0);
    endtask

    task automatic test_random_lengths();
        for (int n = 0; n < 4; n++) begin
            fill_random();
            for (int i = 0; i < LANES; i++) lens[i] = $urandom_range(0, 15);
            compute_ref();
            apply_lens();
            run_and_check(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        for (int i = 0; i < LANES; i++) lens[i] = $urandom_range(0, 8);
        lens[1] = 5;
        compute_ref();
        apply_lens();
        run_and_check(1'b1, 1'b1);
        run_and_check(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_random();
        lens = '{8, 8, 8, 8, 8};
        compute_ref();
        apply_lens();
        ifc.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        for (int i = 0; i < LANES; i++) lens[i] = $urandom_range(1, 8);
        compute_ref();
        apply_lens();
        run_and_check(1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_lane();
        test_mixed_lengths();
        test_overflow();
        test_random_lengths();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mcsr_spmv_array
`default_nettype wire
